// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences the iterative divider and commits HI/LO.
// Optional watchdog abort of a hung divide: define DIV_WATCHDOG_EN.
module hilo_ctrl #(
    parameter int WD_LIMIT = 40
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        w_DivOp,
    input  logic [31:0] w_A,
    input  logic [31:0] w_B,
    input  logic        w_DivStop,
    input  logic        w_DivZero,
    input  logic [31:0] w_DIVHI,
    input  logic [31:0] w_DIVLO,
    input  logic        w_MfSel,
    output logic        w_DivStart,
    output logic [31:0] w_DivA,
    output logic [31:0] w_DivB,
    output logic [31:0] w_HI,
    output logic [31:0] w_LO,
    output logic [31:0] w_ReadData,
    output logic        w_Busy,
    output logic        w_DivDone,
    output logic        w_DivZeroExc,
    output logic        w_Timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        EXC  = 2'd3
    } state_t;

    state_t      state_q;
    logic        start_q;
    logic        busy_q;
    logic        done_q;
    logic        exc_q;
    logic [31:0] diva_q;
    logic [31:0] divb_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

`ifdef DIV_WATCHDOG_EN
    localparam int CW = $clog2(WD_LIMIT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(WD_LIMIT - 1);

    logic [CW-1:0] wd_cnt_q;
    logic          timeout_q;
`else
    logic unused_wd;
    assign unused_wd = (WD_LIMIT > 0);
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            diva_q  <= '0;
            divb_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef DIV_WATCHDOG_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            exc_q  <= 1'b0;
`ifdef DIV_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (w_DivOp) begin
                        busy_q <= 1'b1;
                        if (w_B != 32'd0) begin
                            diva_q  <= w_A;
                            divb_q  <= w_B;
                            start_q <= 1'b1;
                            state_q <= RUN;
`ifdef DIV_WATCHDOG_EN
                            wd_cnt_q <= '0;
`endif
                        end else begin
                            exc_q   <= 1'b1;
                            state_q <= EXC;
                        end
                    end
                end
                RUN: begin
                    // A completed result wins over a late zero flag.
                    if (w_DivStop) begin
                        hi_q    <= w_DIVHI;
                        lo_q    <= w_DIVLO;
                        start_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (w_DivZero) begin
                        start_q <= 1'b0;
                        exc_q   <= 1'b1;
                        state_q <= EXC;
`ifdef DIV_WATCHDOG_EN
                    end else if (wd_cnt_q == WD_LAST) begin
                        start_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
`endif
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                EXC: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign w_DivStart   = start_q;
    assign w_DivA       = diva_q;
    assign w_DivB       = divb_q;
    assign w_HI         = hi_q;
    assign w_LO         = lo_q;
    assign w_Busy       = busy_q;
    assign w_DivDone    = done_q;
    assign w_DivZeroExc = exc_q;
    assign w_ReadData   = w_MfSel ? hi_q : lo_q;

`ifdef DIV_WATCHDOG_EN
    assign w_Timeout = timeout_q;
`else
    assign w_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl with a behavioural iterative-divider model.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_DivOp = 1'b0;
    logic [31:0] w_A = '0;
    logic [31:0] w_B = '0;
    logic        w_DivStop;
    logic        w_DivZero;
    logic [31:0] w_DIVHI = 32'hDEAD_BEEF;
    logic [31:0] w_DIVLO = 32'hDEAD_BEEF;
    logic        w_MfSel = 1'b0;
    logic        w_DivStart;
    logic [31:0] w_DivA, w_DivB, w_HI, w_LO, w_ReadData;
    logic        w_Busy, w_DivDone, w_DivZeroExc, w_Timeout;

    hilo_ctrl #(.WD_LIMIT(40)) dut (
        .Clock(clk), .Reset(rst),
        .w_DivOp(w_DivOp), .w_A(w_A), .w_B(w_B),
        .w_DivStop(w_DivStop), .w_DivZero(w_DivZero),
        .w_DIVHI(w_DIVHI), .w_DIVLO(w_DIVLO), .w_MfSel(w_MfSel),
        .w_DivStart(w_DivStart), .w_DivA(w_DivA), .w_DivB(w_DivB),
        .w_HI(w_HI), .w_LO(w_LO), .w_ReadData(w_ReadData),
        .w_Busy(w_Busy), .w_DivDone(w_DivDone),
        .w_DivZeroExc(w_DivZeroExc), .w_Timeout(w_Timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // 0 = result, 1 = exception, 2 = watchdog timeout
    typedef struct {
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    // divider model
    logic stop_m = 1'b0;
    logic stop_f = 1'b0;
    logic zero_m = 1'b0;
    logic div_en = 1'b1;
    int   run_n = 0;
    int   zero_at = 0;
    int   stop_cyc = 0;

    assign w_DivStop = stop_m | stop_f;
    assign w_DivZero = zero_m;

    always @(negedge clk) begin
        if (w_DivStart) run_n = run_n + 1;
        else run_n = 0;
        stop_m = div_en && w_DivStart && (run_n == 32);
        zero_m = w_DivStart && (run_n == zero_at);
        if (stop_m) begin
            w_DIVHI = w_DivA % w_DivB;
            w_DIVLO = w_DivA / w_DivB;
            stop_cyc = cyc_n;
        end else begin
            w_DIVHI = 32'hDEAD_BEEF;
            w_DIVLO = 32'hDEAD_BEEF;
        end
    end

    // monitor: pops the scoreboard on every DUT event
    logic done_prev = 1'b0;
    logic exc_prev = 1'b0;
    logic busy_prev = 1'b0;
    int   done_cyc = -10;

    always @(negedge clk) begin
        exp_t e;
        if (done_prev) check("done_pulse", w_DivDone, 0);
        if (exc_prev) check("exc_pulse", w_DivZeroExc, 0);
        if (busy_prev && !w_Busy && done_cyc == cyc_n - 1)
            check("busy_lat", cyc_n, stop_cyc + 2);
        if (w_DivDone || w_DivZeroExc || w_Timeout) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {w_DivDone, w_DivZeroExc, w_Timeout}, 0);
            end else begin
                e = sb.pop_front();
                if (w_DivDone) begin
                    check("kind_done", 0, e.kind);
                    check("hi", w_HI, e.hi);
                    check("lo", w_LO, e.lo);
                    check("done_lat", cyc_n, stop_cyc + 1);
                    done_cyc = cyc_n;
                    hi_m = e.hi;
                    lo_m = e.lo;
                end else if (w_DivZeroExc) begin
                    check("kind_exc", 1, e.kind);
                    check("exc_hi", w_HI, hi_m);
                    check("exc_lo", w_LO, lo_m);
                end else begin
                    check("kind_tmo", 2, e.kind);
                    check("tmo_lat", cyc_n, e.cyc);
                    check("tmo_start", w_DivStart, 0);
                    check("tmo_hi", w_HI, hi_m);
                end
            end
        end
        done_prev = w_DivDone;
        exc_prev  = w_DivZeroExc;
        busy_prev = w_Busy;
    end

    int op_cyc = 0;

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        w_DivOp = 1'b1;
        w_A = a;
        w_B = b;
        op_cyc = cyc_n;
        @(negedge clk);
        w_DivOp = 1'b0;
        w_A = '0;
        w_B = '0;
    endtask

    task automatic push(input int kind, input logic [31:0] hi,
                        input logic [31:0] lo, input int cyc);
        exp_t e;
        e.kind = kind;
        e.hi = hi;
        e.lo = lo;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && w_Busy; i++) @(negedge clk);
        check("idle_wait", w_Busy, 0);
    endtask

    logic start_seen;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_hi", w_HI, 0);
        check("rst_lo", w_LO, 0);
        check("rst_diva", w_DivA, 0);
        check("rst_busy", w_Busy, 0);
        check("rst_start", w_DivStart, 0);

        // basic divide 100/7
        push(0, 2, 14, 0);
        issue(100, 7);
        check("t1_start", w_DivStart, 1);
        check("t1_busy", w_Busy, 1);
        check("t1_diva", w_DivA, 100);
        check("t1_divb", w_DivB, 7);
        wait_idle(50);

        // zero divisor from register file
        push(1, 0, 0, 0);
        start_seen = 1'b0;
        issue(5, 0);
        check("t2_exc", w_DivZeroExc, 1);
        check("t2_diva", w_DivA, 100);
        check("t2_divb", w_DivB, 7);
        for (int i = 0; i < 3; i++) begin
            start_seen |= w_DivStart;
            @(negedge clk);
        end
        check("t2_nostart", start_seen, 0);
        check("t2_hi", w_HI, 2);
        check("t2_lo", w_LO, 14);

        // new request while busy is dropped
        push(0, 2, 14, 0);
        issue(100, 7);
        repeat (4) @(negedge clk);
        w_DivOp = 1'b1;
        w_A = 9;
        w_B = 3;
        @(negedge clk);
        w_DivOp = 1'b0;
        check("t3_diva", w_DivA, 100);
        check("t3_divb", w_DivB, 7);
        wait_idle(50);

        // reads return committed values during a run
        push(0, 10, 30, 0);
        issue(1000, 33);
        for (int i = 0; i < 6; i++) begin
            w_MfSel = i[0];
            #1;
            check("t4_rd", w_ReadData, i[0] ? 32'd2 : 32'd14);
            @(negedge clk);
        end
        wait_idle(50);
        w_MfSel = 1'b1;
        #1;
        check("t4_rd_hi", w_ReadData, 10);
        w_MfSel = 1'b0;

        // divider zero flag mid-run
        zero_at = 5;
        push(1, 0, 0, 0);
        issue(50, 6);
        wait_idle(20);
        check("t5_diva", w_DivA, 50);

        // stop and zero together: result wins
        zero_at = 32;
        push(0, 2, 8, 0);
        issue(50, 6);
        wait_idle(50);
        zero_at = 0;

        // divider never finishes
        div_en = 1'b0;
`ifdef DIV_WATCHDOG_EN
        issue(77, 5);
        push(2, 0, 0, op_cyc + 41);
        wait_idle(60);
        check("t6_hi", w_HI, hi_m);
`else
        issue(77, 5);
        repeat (60) @(negedge clk);
        check("t6_busy", w_Busy, 1);
        check("t6_start", w_DivStart, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_busy", w_Busy, 0);
        hi_m = '0;
        lo_m = '0;
`endif
        div_en = 1'b1;

        // reset mid-run, then a stray stop
        issue(100, 7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        check("t7_start", w_DivStart, 0);
        check("t7_busy", w_Busy, 0);
        check("t7_hi", w_HI, 0);
        check("t7_lo", w_LO, 0);
        check("t7_diva", w_DivA, 0);
        stop_f = 1'b1;
        @(negedge clk);
        stop_f = 1'b0;
        repeat (2) @(negedge clk);
        check("t7_hi2", w_HI, 0);
        check("t7_lo2", w_LO, 0);

        check("sb_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter: WD_LIMIT, default 40, max RUN cycles before watchdog abort (used only with DIV_WATCHDOG_EN).
REQ-002 Clock  in  1  single clock; all state updates on posedge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 w_DivOp  in  1  one-cycle DIV request pulse from control unit.
REQ-005 w_A, w_B  in  32 each  dividend and divisor from register file, valid with w_DivOp.
REQ-006 w_DivStop, w_DivZero  in  1 each  done and zero-divisor flags from divider.
REQ-007 w_DIVHI, w_DIVLO  in  32 each  divider remainder and quotient, valid while w_DivStop=1.
REQ-008 w_MfSel  in  1  read select: 0=LO, 1=HI.
REQ-009 w_DivStart  out  1  divider start, level-held.
REQ-010 w_DivA, w_DivB  out  32 each  latched operands to divider, stable for the whole operation.
REQ-011 w_HI, w_LO  out  32 each  architectural HI/LO registers.
REQ-012 w_ReadData  out  32  combinational: w_MfSel ? w_HI : w_LO.
REQ-013 w_Busy  out  1  operation in flight; control unit stalls MFHI/MFLO and new DIV while high.
REQ-014 w_DivDone  out  1  one-cycle pulse, HI/LO updated.
REQ-015 w_DivZeroExc  out  1  one-cycle pulse, divide-by-zero exception to control unit.
REQ-016 w_Timeout  out  1  one-cycle pulse, watchdog abort (tied 0 without DIV_WATCHDOG_EN).

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE, EXC; registered, one-hot or binary at implementer's choice.
REQ-018 IDLE: w_DivOp=1 and w_B!=0 -> latch w_A/w_B into w_DivA/w_DivB, go RUN.
REQ-019 IDLE: w_DivOp=1 and w_B==0 -> go EXC; w_DivStart never asserted, operands not latched.
REQ-020 RUN: w_DivStart=1 every cycle in RUN and 0 in all other states.
REQ-021 RUN: w_DivStop=1 sampled -> HI<=w_DIVHI, LO<=w_DIVLO on that edge, go DONE.
REQ-022 RUN: w_DivZero=1 sampled (and w_DivStop=0) -> go EXC, HI/LO unchanged; w_DivZero has priority only when w_DivStop=0.
REQ-023 DONE: w_DivDone=1 for exactly one cycle, then IDLE.
REQ-024 EXC: w_DivZeroExc=1 for exactly one cycle, then IDLE; HI/LO unchanged.
REQ-025 w_Busy SHALL be 1 in RUN, DONE, EXC; 0 in IDLE.
REQ-026 Latency: w_DivOp at cycle N -> w_DivStart=1 from N+1; w_DivStop at cycle M -> w_HI/w_LO new and w_DivDone=1 at M+1, w_Busy=0 at M+2.
REQ-027 w_DivOp while w_Busy=1 SHALL be ignored (no state, operand or HI/LO change).
REQ-028 w_DivA/w_DivB SHALL hold until next accepted request; not cleared on DONE/EXC.
REQ-029 HI/LO SHALL be written only in REQ-021; never partially.
REQ-030 w_ReadData valid in any state; MFHI/MFLO returns committed (old) values while w_Busy=1.

Reset
REQ-031 Reset=1 at any posedge, including mid-RUN: state IDLE, w_HI=w_LO=0, w_DivA=w_DivB=0, watchdog count 0, all pulse outputs and w_DivStart/w_Busy 0 from next cycle.
REQ-032 Reset SHALL dominate w_DivOp and w_DivStop in the same cycle.

Configuration
REQ-033 Macro DIV_WATCHDOG_EN: when defined, a counter clears on RUN entry, increments each RUN cycle; reaching WD_LIMIT without w_DivStop -> w_DivStart dropped, go IDLE with w_Timeout one-cycle pulse in that IDLE cycle, HI/LO unchanged.
REQ-034 Without DIV_WATCHDOG_EN: no counter logic, w_Timeout tied 0, RUN waits indefinitely.

Verification
REQ-035 w_A=100, w_B=7, divider model stops after 32 cycles with HI=2, LO=14 -> w_HI=2, w_LO=14, w_DivDone one pulse, w_Busy low 2 cycles after stop.
REQ-036 w_A=5, w_B=0 -> w_DivZeroExc pulse next cycle, w_DivStart never 1, w_HI/w_LO keep prior values.
REQ-037 Second w_DivOp (A=9, B=3) mid-RUN -> ignored, w_DivA stays 100, result still 2/14.
REQ-038 Reset asserted 10 cycles into RUN -> next cycle w_DivStart=0, w_Busy=0, w_HI=w_LO=0; later w_DivStop pulse causes no write.
REQ-039 With DIV_WATCHDOG_EN, WD_LIMIT=40, w_DivStop held 0 -> w_Timeout pulse 41 cycles after w_DivOp, w_DivStart low, HI/LO unchanged.
REQ-040 w_MfSel toggled during RUN after HI=2, LO=14 committed -> w_ReadData alternates 2/14 unchanged until next w_DivDone.
